// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM state type and one-hot helper for the round-robin
// arbiter that drives the 4:1 output mux.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first active request found scanning from
// i_ptr upward (mod N_REQ).
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic             o_found,
    output logic [SEL_W-1:0] o_idx
);

    // Scan from the far end back toward i_ptr so the nearest hit is the last written.
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[i_ptr + SEL_W'(k)]) begin
                o_found = 1'b1;
                o_idx   = i_ptr + SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the 4:1 select: grants one requester for a
// bounded burst and forwards its word over valid/ready.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DW    = 2,
    parameter int BURST = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic [DW-1:0]    i_din_a,
    input  logic [DW-1:0]    i_din_b,
    input  logic [DW-1:0]    i_din_c,
    input  logic [DW-1:0]    i_din_d,
    input  logic             i_out_ready,
    output logic [N_REQ-1:0] o_gnt,
    output logic [SEL_W-1:0] o_sel,
    output logic [N_REQ-1:0] o_ack,
    output logic             o_out_valid,
    output logic [DW-1:0]    o_out_data
);

    localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

    arb_state_e              r_state, w_state_nxt;
    logic [SEL_W-1:0]        r_sel, w_sel_nxt;
    logic [SEL_W-1:0]        r_ptr, w_ptr_nxt;
    logic [N_REQ-1:0]        r_gnt, w_gnt_nxt;
    logic [3:0]              r_beat, w_beat_nxt;
    logic [SEL_W-1:0]        w_pick_ptr, w_pick_idx;
    logic                    w_found, w_busy, w_xfer, w_release;
    logic [N_REQ-1:0][DW-1:0] w_din;

    assign w_din       = {i_din_d, i_din_c, i_din_b, i_din_a};
    assign w_busy      = (r_state == BUSY);
    assign o_out_valid = w_busy & i_req[r_sel];
    assign o_out_data  = o_out_valid ? w_din[r_sel] : '0;
    assign w_xfer      = o_out_valid & i_out_ready;
    assign o_ack       = w_xfer ? onehot(r_sel) : '0;
    assign o_gnt       = r_gnt;
    assign o_sel       = r_sel;

    assign w_release  = w_busy & (~i_req[r_sel] | (w_xfer & (r_beat == LAST_BEAT)));
    // On release the current owner drops to lowest priority for the same-cycle re-pick.
    assign w_pick_ptr = w_busy ? r_sel + SEL_W'(1) : r_ptr;

    rr_pick u_pick (
        .i_req   (i_req),
        .i_ptr   (w_pick_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_beat_nxt  = r_beat;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = BUSY;
                    w_sel_nxt   = w_pick_idx;
                    w_gnt_nxt   = onehot(w_pick_idx);
                    w_beat_nxt  = '0;
                end
            end
            BUSY: begin
                if (w_release) begin
                    w_ptr_nxt  = w_pick_ptr;
                    w_beat_nxt = '0;
                    if (w_found) begin
                        w_sel_nxt = w_pick_idx;
                        w_gnt_nxt = onehot(w_pick_idx);
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else if (w_xfer) begin
                    w_beat_nxt = r_beat + 4'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: expected transfers are queued as
// stimulus is applied and popped whenever the DUT acks a word.
module tb_mux_rr_arbiter;

    localparam int DW    = 2;
    localparam int BURST = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic [DW-1:0] din_a, din_b, din_c, din_d;
    logic          out_ready;
    logic [3:0]    gnt, ack;
    logic [1:0]    sel;
    logic          out_valid;
    logic [DW-1:0] out_data;

    typedef struct {
        logic [3:0]    ack;
        logic [DW-1:0] data;
    } xfer_t;

    xfer_t sb[$];
    xfer_t mon_e;
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.DW(DW), .BURST(BURST)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_din_a     (din_a),
        .i_din_b     (din_b),
        .i_din_c     (din_c),
        .i_din_d     (din_d),
        .i_out_ready (out_ready),
        .o_gnt       (gnt),
        .o_sel       (sel),
        .o_ack       (ack),
        .o_out_valid (out_valid),
        .o_out_data  (out_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int who, input logic [DW-1:0] d, input int n);
        xfer_t x;
        x.ack  = 4'b0001 << who;
        x.data = d;
        for (int i = 0; i < n; i++) sb.push_back(x);
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Every acked word must be the next one queued by the stimulus.
    always @(negedge clk) begin
        if (|ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("xfer_ack", 32'(ack), 32'(mon_e.ack));
                chk("xfer_data", 32'(out_data), 32'(mon_e.data));
            end
        end
    end

    initial begin
        rst_n = 1'b0; req = '0; out_ready = 1'b0;
        din_a = '0; din_b = '0; din_c = '0; din_d = '0;
        tick(); tick();
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        tick(); rst_n = 1'b1;
        tick();

        // Single requester a: two back-to-back bursts, no bubble at re-grant.
        din_a = 2'b10; out_ready = 1'b1; req = 4'b0001;
        push(0, 2'b10, 2 * BURST);
        @(negedge clk);
        chk("s1_pre_gnt", 32'(gnt), 32'd0);
        chk("s1_pre_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("s1_gnt", 32'(gnt), 32'b0001);
        chk("s1_sel", 32'(sel), 32'd0);
        chk("s1_valid", 32'(out_valid), 32'd1);
        repeat (2 * BURST - 1) tick();
        @(negedge clk);
        chk("s1_regrant_gnt", 32'(gnt), 32'b0001);
        tick(); req = 4'b0000;
        chk("s1_drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
        chk("s1_drop_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("s1_idle_gnt", 32'(gnt), 32'd0);

        // All four requesting: a,b,c,d,a with full bursts and zero-bubble handover.
        tick(); rst_pulse();
        din_a = 2'd0; din_b = 2'd1; din_c = 2'd2; din_d = 2'd3; req = 4'b1111;
        push(0, 2'd0, BURST); push(1, 2'd1, BURST); push(2, 2'd2, BURST);
        push(3, 2'd3, BURST); push(0, 2'd0, BURST);
        repeat (BURST + 1) tick();
        @(negedge clk);
        chk("s2_gnt_b", 32'(gnt), 32'b0010);
        chk("s2_sel_b", 32'(sel), 32'd1);
        repeat (4 * BURST) tick();
        req = 4'b0000;
        chk("s2_drain", 32'(sb.size()), 32'd0);

        // Stall on b: valid and data held, no ack, burst count frozen.
        tick(); rst_pulse();
        din_a = 2'b10; din_b = 2'b01; out_ready = 1'b0; req = 4'b0010;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s3_stall_valid", 32'(out_valid), 32'd1);
            chk("s3_stall_data", 32'(out_data), 32'b01);
            chk("s3_stall_ack", 32'(ack), 32'd0);
            chk("s3_stall_gnt", 32'(gnt), 32'b0010);
            tick();
        end
        out_ready = 1'b1; req = 4'b0011;
        push(1, 2'b01, BURST); push(0, 2'b10, 2);
        repeat (BURST + 2) tick();
        req = 4'b0000;
        chk("s3_drain", 32'(sb.size()), 32'd0);

        // Abandon by c hands over to d; then reset during d's second beat.
        tick(); rst_pulse();
        din_c = 2'b11; din_d = 2'b01; req = 4'b1100;
        push(2, 2'b11, 1);
        tick();
        @(negedge clk);
        chk("s4_gnt_c", 32'(gnt), 32'b0100);
        tick(); req = 4'b1000;
        @(negedge clk);
        chk("s4_dead_valid", 32'(out_valid), 32'd0);
        chk("s4_dead_data", 32'(out_data), 32'd0);
        chk("s4_dead_ack", 32'(ack), 32'd0);
        push(3, 2'b01, 2);
        tick();
        @(negedge clk);
        chk("s4_gnt_d", 32'(gnt), 32'b1000);
        chk("s4_sel_d", 32'(sel), 32'd3);
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1; req = 4'b1111;
        @(negedge clk);
        chk("s4_rst_gnt", 32'(gnt), 32'd0);
        chk("s4_rst_sel", 32'(sel), 32'd0);
        chk("s4_rst_valid", 32'(out_valid), 32'd0);
        chk("s4_rst_ack", 32'(ack), 32'd0);
        push(0, 2'b10, BURST); push(1, 2'b01, 1);
        tick();
        @(negedge clk);
        chk("s4_post_rst_gnt_a", 32'(gnt), 32'b0001);
        repeat (BURST + 1) tick();
        req = 4'b0000;
        chk("s4_drain", 32'(sb.size()), 32'd0);

        // Abandon with nobody else waiting falls back to IDLE.
        tick(); req = 4'b0100;
        push(2, 2'b11, 1);
        tick();
        tick(); req = 4'b0000;
        @(negedge clk);
        chk("s5_dead_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("s5_idle_gnt", 32'(gnt), 32'd0);
        chk("s5_idle_valid", 32'(out_valid), 32'd0);
        chk("s5_drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
